// File: rtl/fifo_arb_pkg.sv
// Shared parameters and state encoding for the FIFO write arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_arb_pkg;

    localparam int N_REQ_DEF     = 4;
    localparam int DATA_W_DEF    = 8;
    localparam int MAX_BURST_DEF = 4;
    localparam int CNT_W         = 3;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Owner index width, kept at least one bit for a single requester.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit
// searching upward from one past the last owner, with wrap-around.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
) (
    input  logic [N_REQ-1:0]          i_req,
    input  logic [owner_w(N_REQ)-1:0] i_last_owner,
    output logic [owner_w(N_REQ)-1:0] o_next,
    output logic                      o_valid
);

    localparam int OW = owner_w(N_REQ);

    int w_idx;

    always_comb begin
        w_idx   = 0;
        o_next  = '0;
        o_valid = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = (int'(i_last_owner) + k) % N_REQ;
            if (!o_valid && i_req[w_idx]) begin
                o_next  = OW'(w_idx);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Arbitrates N requesters into one write port of a buffer, granting
// round-robin bursts of up to MAX_BURST words or one packet.
module fifo_write_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = N_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   src_data,
    input  logic [N_REQ-1:0]          last,
    input  logic                      fifo_full,
    output logic [N_REQ-1:0]          ack,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din,
    output logic [owner_w(N_REQ)-1:0] owner,
    output logic                      busy
);

    localparam int OW = owner_w(N_REQ);

    logic [0:0]       r_state;
    logic [OW-1:0]    r_owner;
    logic [CNT_W-1:0] r_cnt;

    logic             w_burst;
    logic             w_sel_req;
    logic             w_sel_last;
    logic             w_wr;
    logic             w_done;
    logic [CNT_W-1:0] w_cnt_nx;
    logic [OW-1:0]    w_next;
    logic             w_valid;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_pick (
        .i_req        (req),
        .i_last_owner (r_owner),
        .o_next       (w_next),
        .o_valid      (w_valid)
    );

    assign w_burst    = (r_state == ST_BURST);
    assign w_sel_req  = req[r_owner];
    assign w_sel_last = last[r_owner];
    assign w_wr       = w_burst & w_sel_req & ~fifo_full;
    assign w_cnt_nx   = r_cnt + 1'b1;
    // last and the burst limit on the same word still give one exit.
    assign w_done     = w_sel_last | (w_cnt_nx == CNT_W'(MAX_BURST));

    always_comb begin
        ack      = '0;
        fifo_din = '0;
        if (w_burst) begin
            fifo_din = src_data[int'(r_owner)*DATA_W +: DATA_W];
            ack[r_owner] = w_wr;
        end
    end

    assign fifo_wr = w_wr;
    assign owner   = r_owner;
    assign busy    = w_burst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= OW'(N_REQ - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner <= w_next;
                        r_cnt   <= '0;
                        r_state <= ST_BURST;
                    end
                end
                default: begin
                    if (!w_sel_req) begin
                        r_state <= ST_IDLE;
                    end else if (w_wr) begin
                        r_cnt <= w_cnt_nx;
                        if (w_done) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed vector bench for fifo_write_arbiter: per-cycle table
// plus a hand sequence for asynchronous reset during a burst.
module tb_fifo_write_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] src_data;
    logic [3:0]  last;
    logic        fifo_full;
    logic [3:0]  ack;
    logic        fifo_wr;
    logic [7:0]  fifo_din;
    logic [1:0]  owner;
    logic        busy;

    fifo_write_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .src_data  (src_data),
        .last      (last),
        .fifo_full (fifo_full),
        .ack       (ack),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .owner     (owner),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] last;
        logic       full;
        logic [3:0] ack;
        logic       wr;
        logic [7:0] din;
        logic [1:0] own;
        logic       busy;
    } vec_t;

    vec_t vq[$];
    int   checks;
    int   errors;

    function automatic logic [7:0] dat(input int i);
        return 8'hA0 + 8'(8'h11 * i);
    endfunction

    task automatic v(input logic r, input logic [3:0] rq,
                     input logic [3:0] ls, input logic fl,
                     input logic [3:0] ak, input logic wr,
                     input logic [7:0] dn, input logic [1:0] ow,
                     input logic bz);
        vec_t e;
        e.rst = r; e.req = rq; e.last = ls; e.full = fl;
        e.ack = ak; e.wr = wr; e.din = dn; e.own = ow; e.busy = bz;
        vq.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [15:0] exp);
        logic [15:0] act;
        act = {ack, fifo_wr, fifo_din, owner, busy};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got ack=%b wr=%b din=%h own=%0d busy=%b, want ack=%b wr=%b din=%h own=%0d busy=%b",
                     nm, act[15:12], act[11], act[10:3], act[2:1], act[0],
                     exp[15:12], exp[11], exp[10:3], exp[2:1], exp[0]);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        last      = '0;
        fifo_full = 1'b0;
        src_data  = {dat(3), dat(2), dat(1), dat(0)};
        checks    = 0;
        errors    = 0;

        // reset, then single requester with last on word 3
        v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
        v(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
        v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, dat(0), 2'd0, 1);
        v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, dat(0), 2'd0, 1);
        v(0, 4'b0001, 4'b0001, 0, 4'b0001, 1, dat(0), 2'd0, 1);
        v(0, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd0, 0);

        // round robin from a fresh reset, all requesting, no last
        v(1, 4'b0000, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
        for (int g = 0; g < 4; g++) begin
            v(0, 4'b1111, 4'b0000, 0, 4'b0000, 0, 8'h00,
              (g == 0) ? 2'd3 : 2'(g - 1), 0);
            for (int w = 0; w < 4; w++)
                v(0, 4'b1111, 4'b0000, 0, 4'(1 << g), 1, dat(g), 2'(g), 1);
        end

        // full stall on burst cycles 2-5, four words in total
        v(0, 4'b0001, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
        v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, dat(0), 2'd0, 1);
        for (int s = 0; s < 4; s++)
            v(0, 4'b0001, 4'b0000, 1, 4'b0000, 0, dat(0), 2'd0, 1);
        for (int w = 0; w < 3; w++)
            v(0, 4'b0001, 4'b0000, 0, 4'b0001, 1, dat(0), 2'd0, 1);

        // owner 2 abandons after one word, then 3 is granted
        v(0, 4'b0100, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd0, 0);
        v(0, 4'b1100, 4'b0000, 0, 4'b0100, 1, dat(2), 2'd2, 1);
        v(0, 4'b1000, 4'b0000, 0, 4'b0000, 0, dat(2), 2'd2, 1);
        v(0, 4'b1001, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd2, 0);
        v(0, 4'b1000, 4'b1000, 0, 4'b1000, 1, dat(3), 2'd3, 1);

        // last coincides with the fourth word
        v(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd3, 0);
        for (int w = 0; w < 3; w++)
            v(0, 4'b0010, 4'b0000, 0, 4'b0010, 1, dat(1), 2'd1, 1);
        v(0, 4'b0010, 4'b0010, 0, 4'b0010, 1, dat(1), 2'd1, 1);
        v(0, 4'b0010, 4'b0000, 0, 4'b0000, 0, 8'h00, 2'd1, 0);
        v(0, 4'b0011, 4'b0000, 0, 4'b0010, 1, dat(1), 2'd1, 1);

        foreach (vq[i]) begin
            rst       = vq[i].rst;
            req       = vq[i].req;
            last      = vq[i].last;
            fifo_full = vq[i].full;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {vq[i].ack, vq[i].wr, vq[i].din, vq[i].own, vq[i].busy});
            @(posedge clk);
            #1;
        end

        // word 2 of owner 1's burst, reset pulsed between edges
        req  = 4'b0011;
        last = 4'b0000;
        #1;
        chk("pre_rst", {4'b0010, 1'b1, dat(1), 2'd1, 1'b1});
        rst = 1'b1;
        #1;
        chk("rst_async", {4'b0000, 1'b0, 8'h00, 2'd3, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst", {4'b0001, 1'b1, dat(0), 2'd0, 1'b1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 Parameters: N_REQ, default 4, number of requesters.
REQ-002 Parameters: DATA_W, default 8, word width; matches the 8-bit buffer datapath.
REQ-003 Parameters: MAX_BURST, default 4, maximum words per grant.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 req  input  N_REQ  per-requester "word available".
REQ-007 src_data  input  N_REQ*DATA_W  requester words; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-008 last  input  N_REQ  per-requester "current word ends packet".
REQ-009 fifo_full  input  1  downstream buffer full.
REQ-010 ack  output  N_REQ  one-hot; word of requester i accepted this cycle.
REQ-011 fifo_wr  output  1  write strobe to buffer.
REQ-012 fifo_din  output  DATA_W  write data to buffer.
REQ-013 owner  output  log2(N_REQ)  current/last granted requester index.
REQ-014 busy  output  1  high while in BURST state.

Function
REQ-015 The FSM SHALL have two states: IDLE and BURST.
REQ-016 In IDLE with any req bit high, the block SHALL select the first requester with req high, searching upward from (owner+1) mod N_REQ with wrap-around.
REQ-017 The block SHALL register that index into owner and enter BURST on the same edge; arbitration latency is one cycle, and no word transfers in IDLE.
REQ-018 In IDLE with req all zero, the block SHALL remain in IDLE and hold owner.
REQ-019 In BURST, fifo_wr SHALL equal req[owner] AND NOT fifo_full, combinationally.
REQ-020 In BURST, fifo_din SHALL equal the src_data slice of owner.
REQ-021 In BURST, ack SHALL be one-hot at owner when fifo_wr is high, else zero.
REQ-022 Outside BURST, fifo_wr SHALL be 0, ack SHALL be 0, and fifo_din SHALL be 0.
REQ-023 A 3-bit word counter SHALL clear on IDLE->BURST and increment on each accepted word (fifo_wr high).
REQ-024 BURST SHALL return to IDLE on an accepted word that has last[owner] high, or that makes the count equal MAX_BURST.
REQ-025 BURST SHALL return to IDLE when req[owner] is low (requester abandons); no write occurs that cycle.
REQ-026 fifo_full high in BURST SHALL stall: no write, no count change, state held, with no timeout.
REQ-027 Requests from non-owners during BURST SHALL be ignored until the next IDLE cycle.
REQ-028 If last[owner] and the MAX_BURST count coincide on the same word, a single exit SHALL occur.
REQ-029 The block SHALL never write while fifo_full is high.

Reset
REQ-030 On rst assertion, the block SHALL immediately enter state IDLE, clear the counter, and set owner = N_REQ-1, so requester 0 has first priority.
REQ-031 On rst assertion, fifo_wr, ack and fifo_din SHALL go to 0 and busy SHALL go to 0 without waiting for clk.
REQ-032 Reset asserted mid-burst SHALL abort the burst; the partial packet is not resumed after reset release.
REQ-033 The first arbitration SHALL occur on the first clk edge after rst deasserts with req nonzero.

Structure
REQ-034 Shared package fifo_arb_pkg SHALL hold N_REQ, DATA_W, MAX_BURST defaults and the state encoding (IDLE=0, BURST=1).
REQ-035 Sub-module rr_pick SHALL be purely combinational: inputs req vector and last owner; outputs next index and valid.
REQ-036 fifo_write_arbiter SHALL instantiate rr_pick exactly once.
REQ-037 The FSM, counter and output muxing SHALL reside in the top module.

Verification
REQ-038 Scenario (single requester): after reset, req=0001 with last on the 3rd word -> owner=0, busy on cycle 1, three fifo_wr pulses, then IDLE.
REQ-039 Scenario (round-robin): req=1111 held with last never asserted -> grants rotate in order 0,1,2,3,0, each burst exactly 4 words, with one IDLE cycle between bursts.
REQ-040 Scenario (full stall): fifo_full=1 for cycles 2-5 of a burst -> fifo_wr=0 and ack=0 during the stall, count frozen, and the burst completes with 4 words total.
REQ-041 Scenario (abandon): owner 2 drops req after 1 word -> IDLE next cycle, and the next grant goes to requester 3 if it is requesting.
REQ-042 Scenario (reset mid-burst): rst pulsed during word 2 of a burst -> outputs 0 immediately, owner=N_REQ-1, and req=0011 afterwards grants requester 0 first.
REQ-043 Scenario (coincident exit): last[owner] high on the 4th word -> a single exit and no extra IDLE cycle.
